led_frame_arbiter: RTL and testbench

Shares the single 8x8 LED matrix between up to four frame sources (keypad echo, animation, status, debug). Selects one owner round-robin and guarantees it a minimum dwell time. Inserts a blanking gap between owners so no mixed frame is scanned. Sits directly upstream of `led_place_8x8_manager` and drives its 64-bit `i_led_data`.

---
 rtl/led_matrix_pkg.sv | 18 +
 rtl/led_rr_pick.sv | 34 +++
 rtl/led_frame_arbiter.sv | 132 +++++++++++++
 tb/tb_led_frame_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix path.
// Holds the frame width, the blank frame constant and the arbiter state
// encoding used by led_frame_arbiter.
// No ports: package only.
package led_matrix_pkg;

  localparam int LED_FRAME_W = 64;
  localparam logic [LED_FRAME_W-1:0] LED_FRAME_BLANK = 64'h0;

  // IDLE: nobody owns the matrix. OWN: one source is being displayed.
  // GAP: blanking interval between two owners.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } led_arb_state_t;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational rotating-priority picker.
// Searches i_valid starting at index i_ptr and wrapping around; the first
// set bit found wins.
// Ports:
//   i_valid  in  N_REQ  request vector
//   i_ptr    in  2      index where the search starts
//   o_found  out 1      at least one request is set
//   o_idx    out 2      index of the winning request (0 when none)
module led_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [1:0]       i_ptr,
  output logic             o_found,
  output logic [1:0]       o_idx
);

  // Walk the candidates from the farthest to the nearest so that the
  // candidate closest to i_ptr is the last to overwrite the result.
  always_comb begin
    int w_k;
    o_found = 1'b0;
    o_idx   = 2'd0;
    w_k     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_k = (int'(i_ptr) + i) % N_REQ;
      if (i_valid[w_k]) begin
        o_found = 1'b1;
        o_idx   = 2'(w_k);
      end
    end
  end

endmodule

// File: rtl/led_frame_arbiter.sv
// Shares one 8x8 LED matrix among up to four frame sources.
// An owner is picked round-robin, kept for at least DWELL_CYCLES when
// others are waiting, and every change of owner is separated by
// BLANK_CYCLES of blank output so no mixed frame reaches the scanner.
// Ports:
//   aclk         in  1          system clock
//   aresetn      in  1          synchronous active-low reset
//   i_req_valid  in  N_REQ      requester k wants the matrix (level)
//   i_req_frame  in  64*N_REQ   frame k in bits [64k+63:64k]
//   o_grant      out N_REQ      one-hot current owner, zero when none
//   o_owner      out 2          index of the current owner
//   o_led_data   out 64         registered frame to the matrix manager
//   o_busy       out 1          high while owning or blanking
module led_frame_arbiter
  import led_matrix_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             i_req_valid,
  input  logic [LED_FRAME_W*N_REQ-1:0] i_req_frame,
  output logic [N_REQ-1:0]             o_grant,
  output logic [1:0]                   o_owner,
  output logic [LED_FRAME_W-1:0]       o_led_data,
  output logic                         o_busy
);

  // One counter serves both the dwell and the blanking interval.
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  led_arb_state_t         r_state;
  logic [N_REQ-1:0]       r_grant;
  logic [1:0]             r_owner;
  logic [LED_FRAME_W-1:0] r_led_data;
  logic                   r_busy;
  logic [1:0]             r_ptr;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_found;
  logic [1:0]             w_idx;
  logic [N_REQ-1:0]       w_win_grant;
  logic                   w_owner_valid;
  logic                   w_other_valid;
  logic                   w_dwell_done;
  logic                   w_blank_done;
  logic                   w_arbitrate;
  logic [1:0]             w_ptr_next;
  logic [LED_FRAME_W-1:0] w_frames [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_frames[k] = i_req_frame[LED_FRAME_W*k +: LED_FRAME_W];
  end

  led_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // r_grant is the owner's one-hot mask while in OWN, so it isolates the
  // owner's request from everybody else's.
  assign w_win_grant   = {{(N_REQ-1){1'b0}}, 1'b1} << w_idx;
  assign w_owner_valid = |(i_req_valid & r_grant);
  assign w_other_valid = |(i_req_valid & ~r_grant);
  assign w_dwell_done  = (r_cnt == CNT_W'(DWELL_CYCLES - 1));
  assign w_blank_done  = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
  assign w_ptr_next    = (r_owner == 2'(N_REQ - 1)) ? 2'd0 : r_owner + 2'd1;

  // A new owner can only be chosen from IDLE or on the final blank cycle,
  // so a request that appears mid-gap waits and one that vanishes first
  // is never served.
  assign w_arbitrate = (r_state == IDLE) || ((r_state == GAP) && w_blank_done);

  // Main FSM. The grant and its first frame are loaded on the same edge;
  // while owning, the owner's frame is re-registered every cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= 2'd0;
      r_led_data <= LED_FRAME_BLANK;
      r_busy     <= 1'b0;
      r_ptr      <= 2'd0;
      r_cnt      <= '0;
    end else if (w_arbitrate) begin
      r_cnt <= '0;
      if (w_found) begin
        r_state    <= OWN;
        r_grant    <= w_win_grant;
        r_owner    <= w_idx;
        r_led_data <= w_frames[w_idx];
        r_busy     <= 1'b1;
      end else begin
        r_state    <= IDLE;
        r_grant    <= '0;
        r_owner    <= 2'd0;
        r_led_data <= LED_FRAME_BLANK;
        r_busy     <= 1'b0;
      end
    end else if (r_state == OWN) begin
      // A dropped owner releases at once; otherwise give way only after
      // the full dwell and only if someone else is actually waiting.
      if (!w_owner_valid || (w_dwell_done && w_other_valid)) begin
        r_state    <= GAP;
        r_grant    <= '0;
        r_led_data <= LED_FRAME_BLANK;
        r_cnt      <= '0;
        r_ptr      <= w_ptr_next;
      end else begin
        r_led_data <= w_frames[r_owner];
        if (!w_dwell_done) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_grant    = r_grant;
  assign o_owner    = r_owner;
  assign o_led_data = r_led_data;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed self-checking bench for led_frame_arbiter with four requesters,
// an 8-cycle dwell and a 2-cycle blanking gap.
module tb_led_frame_arbiter;

  localparam logic [63:0] F0 = 64'hAAAA_0000_0000_0000;
  localparam logic [63:0] F1 = 64'h0000_BBBB_0000_0000;
  localparam logic [63:0] F2 = 64'h0000_0000_CCCC_0000;
  localparam logic [63:0] F3 = 64'h0000_0000_0000_DDDD;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [3:0]   reqValid;
  logic [255:0] reqFrame;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic [63:0]  ledData;
  logic         busy;

  logic [63:0]  frames [4];
  int           order [5];
  int           checks = 0;
  int           errors = 0;

  led_frame_arbiter #(
    .N_REQ        (4),
    .DWELL_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_req_valid (reqValid),
    .i_req_frame (reqFrame),
    .o_grant     (grant),
    .o_owner     (owner),
    .o_led_data  (ledData),
    .o_busy      (busy)
  );

  // Free-running 10-unit clock.
  always #5 aclk = ~aclk;

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    reqValid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence; every input change happens 1 unit after an edge.
  initial begin
    frames   = '{F0, F1, F2, F3};
    order    = '{0, 1, 2, 3, 0};
    aresetn  = 1'b0;
    reqValid = 4'b0000;
    reqFrame = {F3, F2, F1, F0};
    tick(2);
    checkOutput("rst_grant", 64'(grant), 64'h0);
    checkOutput("rst_owner", 64'(owner), 64'h0);
    checkOutput("rst_led", ledData, 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);

    // Reset while req1 owns, then req0 wins from pointer 0.
    aresetn = 1'b1;
    applyStimulus(4'b0010);
    tick(1);
    checkOutput("t1_grant1", 64'(grant), 64'h2);
    checkOutput("t1_owner1", 64'(owner), 64'h1);
    checkOutput("t1_led1", ledData, F1);
    checkOutput("t1_busy1", 64'(busy), 64'h1);
    tick(2);
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    checkOutput("t1_rst_grant", 64'(grant), 64'h0);
    checkOutput("t1_rst_led", ledData, 64'h0);
    checkOutput("t1_rst_busy", 64'(busy), 64'h0);
    applyStimulus(4'b0011);
    tick(1);
    checkOutput("t1_grant0", 64'(grant), 64'h1);
    checkOutput("t1_led0", ledData, F0);
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("t1_gap_grant", 64'(grant), 64'h0);
    checkOutput("t1_gap_busy", 64'(busy), 64'h1);
    tick(1);
    checkOutput("t1_gap2_busy", 64'(busy), 64'h1);
    tick(1);
    checkOutput("t1_idle_busy", 64'(busy), 64'h0);

    // Single requester, frame follows the input with one cycle of lag.
    reqFrame[128 +: 64] = 64'hFF00_FF00_FF00_FF00;
    applyStimulus(4'b0100);
    tick(1);
    checkOutput("t2_grant", 64'(grant), 64'h4);
    checkOutput("t2_owner", 64'(owner), 64'h2);
    checkOutput("t2_led_first", ledData, 64'hFF00_FF00_FF00_FF00);
    tick(4);
    checkOutput("t2_led_t5", ledData, 64'hFF00_FF00_FF00_FF00);
    reqFrame[128 +: 64] = 64'h1;
    tick(1);
    checkOutput("t2_led_t6", ledData, 64'h1);
    tick(34);
    checkOutput("t2_hold_grant", 64'(grant), 64'h4);
    checkOutput("t2_hold_led", ledData, 64'h1);
    applyStimulus(4'b0000);
    tick(3);
    checkOutput("t2_idle_grant", 64'(grant), 64'h0);
    checkOutput("t2_idle_busy", 64'(busy), 64'h0);
    reqFrame[128 +: 64] = F2;

    // Contention between req0 and req3 from a fresh pointer.
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    applyStimulus(4'b1001);
    tick(1);
    checkOutput("t3_grant_t1", 64'(grant), 64'h1);
    checkOutput("t3_led_t1", ledData, F0);
    tick(7);
    checkOutput("t3_grant_t8", 64'(grant), 64'h1);
    tick(1);
    checkOutput("t3_grant_t9", 64'(grant), 64'h0);
    checkOutput("t3_led_t9", ledData, 64'h0);
    checkOutput("t3_busy_t9", 64'(busy), 64'h1);
    tick(1);
    checkOutput("t3_grant_t10", 64'(grant), 64'h0);
    tick(1);
    checkOutput("t3_grant_t11", 64'(grant), 64'h8);
    checkOutput("t3_owner_t11", 64'(owner), 64'h3);
    checkOutput("t3_led_t11", ledData, F3);

    // All four requesting: grants rotate 0,1,2,3,0 with 8 on / 2 blank.
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    applyStimulus(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput($sformatf("t4_grant_start%0d", i), 64'(grant), 64'(4'b0001 << order[i]));
      checkOutput($sformatf("t4_led_start%0d", i), ledData, frames[order[i]]);
      tick(7);
      checkOutput($sformatf("t4_grant_end%0d", i), 64'(grant), 64'(4'b0001 << order[i]));
      tick(1);
      checkOutput($sformatf("t4_gap1_%0d", i), 64'(grant), 64'h0);
      tick(1);
      checkOutput($sformatf("t4_gap2_%0d", i), 64'(grant), 64'h0);
    end

    // Early release by req1 while req0 waits.
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    applyStimulus(4'b0010);
    tick(1);
    checkOutput("t5_grant1", 64'(grant), 64'h2);
    applyStimulus(4'b0011);
    tick(2);
    applyStimulus(4'b0001);
    tick(1);
    checkOutput("t5_blank_grant", 64'(grant), 64'h0);
    checkOutput("t5_blank_led", ledData, 64'h0);
    checkOutput("t5_blank_busy", 64'(busy), 64'h1);
    tick(1);
    checkOutput("t5_blank2_grant", 64'(grant), 64'h0);
    tick(1);
    checkOutput("t5_grant0", 64'(grant), 64'h1);
    checkOutput("t5_led0", ledData, F0);

    // A request present only during the first gap cycle is not served.
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("t6_gap_grant", 64'(grant), 64'h0);
    checkOutput("t6_gap_busy", 64'(busy), 64'h1);
    applyStimulus(4'b0100);
    tick(1);
    checkOutput("t6_gap2_grant", 64'(grant), 64'h0);
    applyStimulus(4'b0000);
    tick(1);
    checkOutput("t6_idle_grant", 64'(grant), 64'h0);
    checkOutput("t6_idle_led", ledData, 64'h0);
    checkOutput("t6_idle_busy", 64'(busy), 64'h0);
    tick(1);
    checkOutput("t6_idle2_grant", 64'(grant), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
